mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits; memory word is DW/8 bytes, big-endian (lowest byte address holds MSB).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0/req1  input  1 each  access request from requester 0 / 1.
REQ-006 we0/we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-007 addr0/addr1  input  AW each  byte address; word-aligned expected.
REQ-008 wdata0/wdata1  input  DW each  write data.
REQ-009 ack0/ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-010 rdata  output  DW  read data, valid in the cycle ackN is high for a read.
REQ-011 err0/err1  output  1 each  misalignment error, valid with ackN (only when the alignment check is compiled in).
REQ-012 mem_wr_en  output  1  write enable to the memory.
REQ-013 mem_addr  output  AW  address to the memory.
REQ-014 mem_data_in  output  DW  write data to the memory.
REQ-015 mem_data_out  input  DW  combinational read data from the memory.

Function
REQ-016 The FSM SHALL have states IDLE, ACC, DONE.
REQ-017 IDLE: if any reqN is high, the arbiter SHALL register the winner's we, addr, wdata and its index, and enter ACC; otherwise it stays in IDLE.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, grant the port not granted last; a lone request is granted immediately.
REQ-019 ACC lasts exactly one cycle: mem_addr and mem_data_in SHALL come from the registered request, and mem_wr_en SHALL equal the registered we.
REQ-020 At the clock edge ending ACC, mem_data_out SHALL be captured into rdata, and the state SHALL go to DONE.
REQ-021 DONE: the granted port's ackN SHALL be high for exactly one cycle; rdata holds for reads and is don't-care for writes.
REQ-022 From DONE, the FSM SHALL behave as IDLE (arbitrate and enter ACC if a request is present) so back-to-back accesses take 2 cycles each.
REQ-023 Latency: an uncontested request sampled in IDLE at edge N SHALL see ackN high in cycle N+2.
REQ-024 A requester SHALL hold reqN/weN/addrN/wdataN stable until ackN; a request still high in the DONE cycle counts as a new request.
REQ-025 A reqN that drops before grant SHALL be ignored; a reqN that drops after grant SHALL still complete.
REQ-026 ack0 and ack1 SHALL never be high in the same cycle; mem_wr_en SHALL be low in IDLE and DONE.
REQ-027 mem_addr and mem_data_in outside ACC SHALL hold their last registered values.

Reset
REQ-028 Asserting rst SHALL immediately force state=IDLE, ack0=ack1=0, err0=err1=0, mem_wr_en=0, mem_addr=0, mem_data_in=0, and rdata=0.
REQ-029 After reset, the round-robin pointer SHALL favour port 0.
REQ-030 Reset during ACC SHALL abort the access, and no memory write SHALL occur.

Configuration
REQ-031 Macro MEM_ARB_ALIGN_CHK_EN.
REQ-032 With MEM_ARB_ALIGN_CHK_EN defined, a granted request with nonzero addr[1:0] SHALL skip the memory access (mem_wr_en stays 0) and complete via DONE with ackN=1 and errN=1.
REQ-033 Without MEM_ARB_ALIGN_CHK_EN, addr[1:0] SHALL be forced to 00 on mem_addr, and err0/err1 SHALL be tied to 0.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state typedef (IDLE/ACC/DONE) and the requester-count constant (2).
REQ-035 The round-robin winner/pointer logic SHALL be the sub-module mem_arb_rr; memory itself is external.

Verification
REQ-036 Port 0 writes 0xDEADBEEF to 0x8, then reads 0x8 -> each access ack0 at +2 cycles; rdata=0xDEADBEEF; memory bytes 8..11 = DE,AD,BE,EF.
REQ-037 req0 and req1 (reads of 0x0 and 0x4) are raised together after reset and held -> grants alternate 0,1,0,1; acks spaced 2 cycles; no cycle has both acks high.
REQ-038 Port 1 write of 0x12345678 to 0x10, with rst pulsed during ACC -> no ack1; word at 0x10 is unchanged; all outputs are 0 during reset.
REQ-039 Port 1 reads 0x6 -> with the macro defined: ack1=1, err1=1, no memory access; without it: rdata equals the word at 0x4.
REQ-040 req0 is raised then dropped before grant while port 1 is being served -> port 0 is never acknowledged, and port 1 completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the two-port memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  localparam int N_REQ = 2;
  localparam int IDX_W = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_if
// Brief    : Requester-side and memory-side signals of the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic          err0, err1;
  logic [DW-1:0] rdata;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, err0, err1, rdata, mem_wr_en, mem_addr, mem_data_in
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, err0, err1, rdata, mem_wr_en, mem_addr, mem_data_in
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_rr
// Brief    : Two-way round-robin winner selection with priority pointer.
// Revision : 1.0  initial release
// ============================================================================
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // prio_q names the port that wins a tie; it always points away from the last winner
  logic [IDX_W-1:0] prio_q, prio_d;

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = prio_q;
    if (!req[prio_q]) begin
      gnt_idx = ~prio_q;
    end
    prio_d = prio_q;
    if (advance && gnt_valid) begin
      prio_d = ~gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter giving two requesters 2-cycle access to one
//            external memory. Define MEM_ARB_ALIGN_CHK_EN to flag misaligned
//            addresses with errN instead of silently aligning them.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [AW-1:0]    sel_addr_fmt;
  logic [DW-1:0]    sel_wdata;
  logic             sel_misal;

  // The pointer only moves when a grant is actually taken (IDLE or DONE).
  mem_arb_rr u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       ({bus.req1, bus.req0}),
    .advance   (state_q != ACC),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (gnt_idx == IDX_W'(1)) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign sel_misal    = |sel_addr[1:0];
  assign sel_addr_fmt = sel_addr;
`else
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);
  assign sel_misal    = 1'b0;
  assign sel_addr_fmt = sel_addr & ALIGN_MASK;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (gnt_valid) begin
          state_d = ACC;
          we_d    = sel_we;
          addr_d  = sel_addr_fmt;
          wdata_d = sel_wdata;
          idx_d   = gnt_idx;
          err_d   = sel_misal;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        state_d = DONE;
        // A flagged access never touches memory, so rdata keeps its old value.
        if (!err_q) begin
          rdata_d = bus.mem_data_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.mem_wr_en   = (state_q == ACC) && we_q && !err_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.ack0        = (state_q == DONE) && (idx_q == IDX_W'(0));
  assign bus.ack1        = (state_q == DONE) && (idx_q == IDX_W'(1));

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign bus.err0 = bus.ack0 && err_q;
  assign bus.err1 = bus.ack1 && err_q;
`else
  assign bus.err0 = 1'b0;
  assign bus.err1 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a byte-wide big-endian
//            memory model and an ack-driven scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam logic [31:0] W0  = 32'h10111213;
  localparam logic [31:0] W4  = 32'h14151617;
  localparam logic [31:0] W10 = 32'h20212223;
  localparam logic [31:0] W28 = 32'h38393A3B;

  typedef struct {
    int          port;
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic clk;
  logic rst;
  logic init_mem;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  logic [7:0] mem [0:63];
  logic [5:0] ma;

  mem_arb_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Big-endian memory model: lowest byte address holds the MSB.
  assign ma = {bus.mem_addr[5:2], 2'b00};
  assign bus.mem_data_out = {mem[ma], mem[ma + 6'd1], mem[ma + 6'd2], mem[ma + 6'd3]};

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i + 16);
    end else if (bus.mem_wr_en) begin
      mem[ma]        <= bus.mem_data_in[31:24];
      mem[ma + 6'd1] <= bus.mem_data_in[23:16];
      mem[ma + 6'd2] <= bus.mem_data_in[15:8];
      mem[ma + 6'd3] <= bus.mem_data_in[7:0];
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  // Scoreboard: every ack pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.ack0 || bus.ack1)) begin
      n_checks++;
      if (bus.ack0 && bus.ack1) $display("FAIL ack_exclusive: ack0=1 ack1=1, required at most one");
      else n_pass++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with no pending request", bus.ack0, bus.ack1);
      end else begin
        n_pass++;
        e = sb.pop_front();
        n_checks++;
        if ((bus.ack1 ? 1 : 0) !== e.port)
          $display("FAIL ack_port: got port %0d, required %0d", bus.ack1 ? 1 : 0, e.port);
        else n_pass++;
        n_checks++;
        if ((bus.ack1 ? bus.err1 : bus.err0) !== e.err)
          $display("FAIL ack_err: got %0b, required %0b", bus.ack1 ? bus.err1 : bus.err0, e.err);
        else n_pass++;
        if (e.rd) begin
          n_checks++;
          if (bus.rdata !== e.data) $display("FAIL rdata: got %h, required %h", bus.rdata, e.data);
          else n_pass++;
        end
      end
    end
  end

  task automatic drive(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  task automatic release_req(input int port);
    if (port == 0) bus.req0 = 1'b0;
    else bus.req1 = 1'b0;
  endtask

  // Returns the number of rising edges until ackN is seen, or -1 after 8.
  task automatic wait_ack(input int port, output int edges);
    edges = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((port == 0 && bus.ack0) || (port == 1 && bus.ack1)) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_wr_en} !== 5'b0)
      $display("FAIL reset_ctrl: ack0,ack1,err0,err1,wr_en=%b, required 00000",
               {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_wr_en});
    else n_pass++;
    n_checks++;
    if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h, required 0", bus.mem_addr);
    else n_pass++;
    n_checks++;
    if (bus.mem_data_in !== 32'h0) $display("FAIL reset_mem_data_in: got %h, required 0", bus.mem_data_in);
    else n_pass++;
    n_checks++;
    if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h, required 0", bus.rdata);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int e;
    @(negedge clk);
    drive(0, 1'b1, 32'h8, 32'hDEADBEEF);
    sb.push_back('{0, 1'b0, 32'h0, 1'b0});
    wait_ack(0, e);
    release_req(0);
    n_checks++;
    if (e !== 2) $display("FAIL write_latency: got %0d edges, required 2", e);
    else n_pass++;
    n_checks++;
    if ({mem[8], mem[9], mem[10], mem[11]} !== 32'hDEADBEEF)
      $display("FAIL write_bytes: got %h %h %h %h, required DE AD BE EF", mem[8], mem[9], mem[10], mem[11]);
    else n_pass++;
    @(negedge clk);
    drive(0, 1'b0, 32'h8, 32'h0);
    sb.push_back('{0, 1'b1, 32'hDEADBEEF, 1'b0});
    wait_ack(0, e);
    release_req(0);
    n_checks++;
    if (e !== 2) $display("FAIL read_latency: got %0d edges, required 2", e);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int got;
    int e;
    do_reset();
    drive(0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 32'h4, 32'h0);
    for (int k = 0; k < 4; k++) sb.push_back('{k % 2, 1'b1, (k % 2 == 0) ? W0 : W4, 1'b0});
    for (int k = 0; k < 4; k++) begin
      got = -1;
      e   = -1;
      for (int i = 1; i <= 8; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.ack0 || bus.ack1) begin
          got = bus.ack1 ? 1 : 0;
          e   = i;
          break;
        end
      end
      n_checks++;
      if (got !== k % 2 || e !== 2)
        $display("FAIL rr_grant%0d: got port %0d after %0d edges, required port %0d after 2", k, got, e, k % 2);
      else n_pass++;
    end
    release_req(0);
    release_req(1);
  endtask

  task automatic test_misaligned();
    int e;
    @(negedge clk);
    drive(1, 1'b0, 32'h6, 32'h0);
`ifdef MEM_ARB_ALIGN_CHK_EN
    sb.push_back('{1, 1'b0, 32'h0, 1'b1});
`else
    sb.push_back('{1, 1'b1, W4, 1'b0});
`endif
    wait_ack(1, e);
    release_req(1);
    n_checks++;
    if (e !== 2) $display("FAIL misal_rd_latency: got %0d edges, required 2", e);
    else n_pass++;
    @(negedge clk);
    drive(1, 1'b1, 32'h2A, 32'hCAFEF00D);
`ifdef MEM_ARB_ALIGN_CHK_EN
    sb.push_back('{1, 1'b0, 32'h0, 1'b1});
`else
    sb.push_back('{1, 1'b0, 32'h0, 1'b0});
`endif
    wait_ack(1, e);
    release_req(1);
    n_checks++;
`ifdef MEM_ARB_ALIGN_CHK_EN
    if (mem_word(40) !== W28) $display("FAIL misal_wr_mem: got %h, required %h", mem_word(40), W28);
`else
    if (mem_word(40) !== 32'hCAFEF00D) $display("FAIL misal_wr_mem: got %h, required CAFEF00D", mem_word(40));
`endif
    else n_pass++;
  endtask

  task automatic test_drop_before_grant();
    int acks0;
    @(negedge clk);
    drive(1, 1'b0, 32'h4, 32'h0);
    sb.push_back('{1, 1'b1, W4, 1'b0});
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.ack1 !== 1'b1) $display("FAIL drop_ack1: got %b, required 1", bus.ack1);
    else n_pass++;
    release_req(0);
    release_req(1);
    acks0 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ack0) acks0++;
    end
    n_checks++;
    if (acks0 !== 0) $display("FAIL drop_ack0: got %0d acks, required 0", acks0);
    else n_pass++;
  endtask

  task automatic test_reset_during_acc();
    int acks1;
    @(negedge clk);
    drive(1, 1'b1, 32'h10, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.mem_wr_en, bus.mem_addr, bus.mem_data_in} !== {1'b1, 32'h10, 32'h12345678})
      $display("FAIL acc_bus: wr_en=%b addr=%h data=%h, required 1 00000010 12345678",
               bus.mem_wr_en, bus.mem_addr, bus.mem_data_in);
    else n_pass++;
    rst = 1'b1;
    release_req(1);
    #1;
    n_checks++;
    if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_wr_en, bus.mem_addr, bus.mem_data_in, bus.rdata} !== '0)
      $display("FAIL rst_in_acc: ctrl=%b addr=%h data_in=%h rdata=%h, required all 0",
               {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_wr_en}, bus.mem_addr, bus.mem_data_in, bus.rdata);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    acks1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ack1) acks1++;
    end
    n_checks++;
    if (acks1 !== 0) $display("FAIL rst_ack1: got %0d acks, required 0", acks1);
    else n_pass++;
    n_checks++;
    if (mem_word(16) !== W10) $display("FAIL rst_mem: got %h, required %h", mem_word(16), W10);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    init_mem = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_misaligned();
    test_drop_before_grant();
    test_reset_during_acc();
    n_checks++;
    if (sb.size() !== 0) $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
